// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, decoder state type and drop-list helper for the PS/2 keyboard receiver
//
// Contents:
//   PS2_E0 / PS2_F0 / PS2_E1   scan-code prefix bytes
//   PS2_* drop-list bytes      keyboard status responses that never reach the matrix
//   PS2_FRAME_LEN              bits per device-to-host frame
//   PS2_PAUSE_SKIP             bytes following E1 in the Pause key sequence
//   dec_state_e                decoder FSM states
//   ps2_is_dropped()           1 when a byte is on the drop list
package ps2_pkg;

    localparam logic [7:0] PS2_E0 = 8'hE0;
    localparam logic [7:0] PS2_F0 = 8'hF0;
    localparam logic [7:0] PS2_E1 = 8'hE1;

    localparam logic [7:0] PS2_OVERRUN0 = 8'h00;
    localparam logic [7:0] PS2_BAT_OK   = 8'hAA;
    localparam logic [7:0] PS2_ECHO     = 8'hEE;
    localparam logic [7:0] PS2_ACK      = 8'hFA;
    localparam logic [7:0] PS2_BAT_FAIL = 8'hFC;
    localparam logic [7:0] PS2_RESEND   = 8'hFE;
    localparam logic [7:0] PS2_OVERRUN  = 8'hFF;

    localparam int         PS2_FRAME_LEN  = 11;
    localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

    typedef enum logic {
        DEC_IDLE  = 1'b0,
        DEC_PAUSE = 1'b1
    } dec_state_e;

    function automatic logic ps2_is_dropped(input logic [7:0] b);
        case (b)
            PS2_OVERRUN0, PS2_BAT_OK, PS2_ECHO, PS2_ACK,
            PS2_BAT_FAIL, PS2_RESEND, PS2_OVERRUN: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_keyboard_if.sv
// rtl/ps2_keyboard_if.sv - key-event bus from the PS/2 decoder to the keyboard matrix
//
// Signals:
//   strobe    one-cycle pulse, new key event on code/pressed/extended
//   pressed   1 = make, 0 = break (held)
//   extended  1 = E0-prefixed event (held)
//   code      scan-code byte without prefixes (held)
//   error     one-cycle pulse on a bad frame or a receive timeout
// Modports: master = decoder side (drives), slave = consumer side.
interface ps2_keyboard_if;

    logic       strobe;
    logic       pressed;
    logic       extended;
    logic [7:0] code;
    logic       error;

    modport master (
        output strobe,
        output pressed,
        output extended,
        output code,
        output error
    );

    modport slave (
        input strobe,
        input pressed,
        input extended,
        input code,
        input error
    );

endinterface

// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 line synchronisers, clock glitch filter, frame deserialiser and timeout
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-low reset
//   ps2Ck      raw PS/2 clock pin (asynchronous)
//   ps2D       raw PS/2 data pin (asynchronous)
//   byteValid  one-cycle pulse, byteData holds a good frame's payload
//   byteData   last good payload byte
//   frameErr   one-cycle pulse on start/parity/stop error or timeout
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 24000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2Ck,
    input  logic       ps2D,
    output logic       byteValid,
    output logic [7:0] byteData,
    output logic       frameErr
);

    localparam int FW       = $clog2(FILTER + 1);
    localparam int TW       = $clog2(TIMEOUT + 1);
    localparam int LAST_BIT = PS2_FRAME_LEN - 1;

    logic [1:0]          ck_sync_q, ck_sync_d;
    logic [1:0]          d_sync_q,  d_sync_d;
    logic                filt_q,    filt_d;
    logic [FW-1:0]       filt_cnt_q, filt_cnt_d;
    logic                fall_q,    fall_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [LAST_BIT-1:0] sr_q,      sr_d;
    logic [TW-1:0]       to_cnt_q,  to_cnt_d;
    logic                valid_q,   valid_d;
    logic [7:0]          byte_q,    byte_d;
    logic                err_q,     err_d;

    logic                ck_s;
    logic                d_s;
    logic                expire;
    logic [3:0]          cur_cnt;
    logic [10:0]         frame;

    assign ck_s = ck_sync_q[1];
    assign d_s  = d_sync_q[1];

    always_comb begin
        ck_sync_d  = {ck_sync_q[0], ps2Ck};
        d_sync_d   = {d_sync_q[0], ps2D};

        // Filtered clock follows the synchronised pin only after FILTER
        // consecutive cycles of disagreement; any agreement restarts the count.
        filt_d     = filt_q;
        filt_cnt_d = '0;
        fall_d     = 1'b0;
        if (ck_s != filt_q) begin
            if (filt_cnt_q == FW'(FILTER - 1)) begin
                filt_d = ck_s;
                fall_d = filt_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end

        // A timeout discards the partial frame first, so a fall landing in
        // the same cycle is taken as bit 0 of a fresh frame.
        expire    = (bit_cnt_q != 4'd0) && (to_cnt_q == TW'(TIMEOUT - 1));
        cur_cnt   = expire ? 4'd0 : bit_cnt_q;

        bit_cnt_d = cur_cnt;
        sr_d      = sr_q;
        valid_d   = 1'b0;
        byte_d    = byte_q;
        err_d     = expire;
        frame     = {d_s, sr_q};
        to_cnt_d  = (cur_cnt == 4'd0) ? '0 : to_cnt_q + 1'b1;

        if (fall_q) begin
            to_cnt_d = '0;
            if (cur_cnt == 4'(LAST_BIT)) begin
                bit_cnt_d = 4'd0;
                // start 0, odd parity over d0..d7+parity, stop 1
                if (!frame[0] && frame[10] && (^frame[9:1])) begin
                    valid_d = 1'b1;
                    byte_d  = frame[8:1];
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                sr_d[cur_cnt] = d_s;
                bit_cnt_d     = cur_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ck_sync_q  <= 2'b11;
            d_sync_q   <= 2'b11;
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
            bit_cnt_q  <= 4'd0;
            sr_q       <= '0;
            to_cnt_q   <= '0;
            valid_q    <= 1'b0;
            byte_q     <= 8'h00;
            err_q      <= 1'b0;
        end else begin
            ck_sync_q  <= ck_sync_d;
            d_sync_q   <= d_sync_d;
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
            fall_q     <= fall_d;
            bit_cnt_q  <= bit_cnt_d;
            sr_q       <= sr_d;
            to_cnt_q   <= to_cnt_d;
            valid_q    <= valid_d;
            byte_q     <= byte_d;
            err_q      <= err_d;
        end
    end

    assign byteValid = valid_q;
    assign byteData  = byte_q;
    assign frameErr  = err_q;

endmodule

// File: rtl/ps2_keyboard.sv
// rtl/ps2_keyboard.sv - PS/2 keyboard receiver top: frame receiver plus set-2 prefix decoder
//
// Ports:
//   clock   system clock, rising edge
//   reset   asynchronous active-low reset
//   ps2Ck   raw PS/2 clock pin
//   ps2D    raw PS/2 data pin
//   kbd     key-event bus (strobe/pressed/extended/code/error), master side
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 24000
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           ps2Ck,
    input  logic           ps2D,
    ps2_keyboard_if.master kbd
);

    logic       byte_valid;
    logic [7:0] rx_byte;
    logic       frame_err;

    ps2_rx_frame #(
        .FILTER  (FILTER),
        .TIMEOUT (TIMEOUT)
    ) u_rx (
        .clock     (clock),
        .reset     (reset),
        .ps2Ck     (ps2Ck),
        .ps2D      (ps2D),
        .byteValid (byte_valid),
        .byteData  (rx_byte),
        .frameErr  (frame_err)
    );

    dec_state_e state_q, state_d;
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [2:0] skip_q, skip_d;
    logic       strobe_q, strobe_d;
    logic       pressed_q, pressed_d;
    logic       extended_q, extended_d;
    logic [7:0] code_q, code_d;
    logic       error_q, error_d;

    always_comb begin
        state_d    = state_q;
        ext_d      = ext_q;
        brk_d      = brk_q;
        skip_d     = skip_q;
        strobe_d   = 1'b0;
        pressed_d  = pressed_q;
        extended_d = extended_q;
        code_d     = code_q;
        // Error frames leave flags and PAUSE progress untouched.
        error_d    = frame_err;

        if (byte_valid) begin
            case (state_q)
                DEC_IDLE: begin
                    if (rx_byte == PS2_E0) begin
                        ext_d = 1'b1;
                    end else if (rx_byte == PS2_F0) begin
                        brk_d = 1'b1;
                    end else if (rx_byte == PS2_E1) begin
                        state_d = DEC_PAUSE;
                        skip_d  = PS2_PAUSE_SKIP;
                    end else if (ext_q || brk_q || !ps2_is_dropped(rx_byte)) begin
                        // Status bytes only count as keys once a prefix was seen.
                        strobe_d   = 1'b1;
                        code_d     = rx_byte;
                        pressed_d  = !brk_q;
                        extended_d = ext_q;
                        ext_d      = 1'b0;
                        brk_d      = 1'b0;
                    end
                end
                DEC_PAUSE: begin
                    // Swallow the rest of the Pause sequence silently.
                    if (skip_q <= 3'd1) begin
                        skip_d  = 3'd0;
                        state_d = DEC_IDLE;
                    end else begin
                        skip_d = skip_q - 3'd1;
                    end
                end
                default: state_d = DEC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= DEC_IDLE;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            skip_q     <= 3'd0;
            strobe_q   <= 1'b0;
            pressed_q  <= 1'b0;
            extended_q <= 1'b0;
            code_q     <= 8'h00;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            skip_q     <= skip_d;
            strobe_q   <= strobe_d;
            pressed_q  <= pressed_d;
            extended_q <= extended_d;
            code_q     <= code_d;
            error_q    <= error_d;
        end
    end

    assign kbd.strobe   = strobe_q;
    assign kbd.pressed  = pressed_q;
    assign kbd.extended = extended_q;
    assign kbd.code     = code_q;
    assign kbd.error    = error_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// tb/tb_ps2_keyboard.sv - scoreboard bench for ps2_keyboard
module tb_ps2_keyboard;

    localparam int FILTER  = 8;
    localparam int TIMEOUT = 24000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ps2_ck = 1'b1;
    logic ps2_d  = 1'b1;

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle++;

    ps2_keyboard_if kbd_if ();

    ps2_keyboard #(
        .FILTER  (FILTER),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock  (clk),
        .reset  (rst_n),
        .ps2Ck  (ps2_ck),
        .ps2D   (ps2_d),
        .kbd    (kbd_if)
    );

    typedef struct {
        logic       is_err;
        logic [7:0] code;
        logic       pressed;
        logic       ext;
        logic       chk_lat;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;
    int   last_stop_fall = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, want, cycle);
    endtask

    task automatic push_key(input logic [7:0] c, input logic p, input logic x);
        exp_t e;
        e.is_err = 1'b0; e.code = c; e.pressed = p; e.ext = x; e.chk_lat = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic push_err(input logic lat);
        exp_t e;
        e.is_err = 1'b1; e.code = 8'h00; e.pressed = 1'b0; e.ext = 1'b0; e.chk_lat = lat;
        exp_q.push_back(e);
    endtask

    function automatic logic [10:0] mk(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bit per 40 cycles: 10 high, 20 low, 10 high; glitch adds short
    // spikes inside the low phase of bit 4 and the high phase of bit 6.
    task automatic send_bits(input logic [10:0] f, input int nbits, input bit glitch);
        for (int i = 0; i < nbits; i++) begin
            ps2_d = f[i];
            wait_cyc(10);
            ps2_ck = 1'b0;
            if (i == 10) last_stop_fall = cycle;
            if (glitch && i == 4) begin
                wait_cyc(12); ps2_ck = 1'b1; wait_cyc(3); ps2_ck = 1'b0; wait_cyc(5);
            end else begin
                wait_cyc(20);
            end
            ps2_ck = 1'b1;
            if (glitch && i == 6) begin
                wait_cyc(14); ps2_ck = 1'b0; wait_cyc(3); ps2_ck = 1'b1; wait_cyc(3);
            end else begin
                wait_cyc(10);
            end
        end
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(mk(b, 1'b0, 1'b0), 11, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_strobe"},   kbd_if.strobe,   1'b0);
        check({tag, "_error"},    kbd_if.error,    1'b0);
        check({tag, "_pressed"},  kbd_if.pressed,  1'b0);
        check({tag, "_extended"}, kbd_if.extended, 1'b0);
        check({tag, "_code"},     kbd_if.code,     8'h00);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    initial begin
        exp_t       e;
        logic [9:0] prev;
        logic [9:0] cur;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {kbd_if.code, kbd_if.pressed, kbd_if.extended};
            if (!rst_n) begin
                prev = cur;
                continue;
            end
            if (kbd_if.strobe && kbd_if.error) begin
                total++;
                $display("FAIL strobe_and_error: both high at cycle %0d, required exclusive", cycle);
            end else if (kbd_if.strobe || kbd_if.error) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_event: strobe=%0b error=%0b code=%0h, required none (cycle %0d)",
                             kbd_if.strobe, kbd_if.error, kbd_if.code, cycle);
                end else begin
                    e = exp_q.pop_front();
                    check("event_is_error", kbd_if.error, e.is_err);
                    if (!e.is_err) begin
                        check("code",     kbd_if.code,     e.code);
                        check("pressed",  kbd_if.pressed,  e.pressed);
                        check("extended", kbd_if.extended, e.ext);
                    end
                    if (e.chk_lat) check("latency", cycle - last_stop_fall, FILTER + 4);
                end
            end
            if (!kbd_if.strobe && cur != prev) begin
                total++;
                $display("FAIL hold_outputs: changed %0h -> %0h without strobe, required held", prev, cur);
            end
            prev = cur;
        end
    end

    initial begin
        wait_cyc(5);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        wait_cyc(10);

        // plain make, break, extended combos
        push_key(8'h1C, 1'b1, 1'b0); send(8'h1C);
        send(8'hF0); push_key(8'h1C, 1'b0, 1'b0); send(8'h1C);
        send(8'hE0); send(8'hF0); push_key(8'h75, 1'b0, 1'b1); send(8'h75);
        send(8'hF0); send(8'hE0); push_key(8'h75, 1'b0, 1'b1); send(8'h75);
        push_key(8'h75, 1'b1, 1'b0); send(8'h75);

        // Pause sequence swallowed, next key decodes
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        push_key(8'h16, 1'b1, 1'b0); send(8'h16);

        // framing errors: parity, stop, start
        push_err(1'b1); send_bits(mk(8'h1C, 1'b1, 1'b0), 11, 1'b0);
        push_err(1'b1); send_bits(mk(8'h1C, 1'b0, 1'b1), 11, 1'b0);
        push_err(1'b1); send_bits(mk(8'h1C, 1'b0, 1'b0) | 11'h001, 11, 1'b0);

        // drop list, and drop-list byte after a prefix
        send(8'hAA); send(8'hFA);
        send(8'hF0); push_key(8'hAA, 1'b0, 1'b0); send(8'hAA);

        // error frame keeps the break flag
        send(8'hF0);
        push_err(1'b1); send_bits(mk(8'h1C, 1'b1, 1'b0), 11, 1'b0);
        push_key(8'h1C, 1'b0, 1'b0); send(8'h1C);

        // timeout after 5 bits, then a good frame
        push_err(1'b0); send_bits(mk(8'h1C, 1'b0, 1'b0), 5, 1'b0);
        wait_cyc(TIMEOUT + 10);
        push_key(8'h1C, 1'b1, 1'b0); send(8'h1C);

        // clock glitches mid-frame
        push_key(8'h5A, 1'b1, 1'b0); send_bits(mk(8'h5A, 1'b0, 1'b0), 11, 1'b1);

        // reset after bit 6 with E0 pending
        send(8'hE0);
        send_bits(mk(8'h1C, 1'b0, 1'b0), 7, 1'b0);
        rst_n = 1'b0;
        wait_cyc(3);
        check_reset_outputs("midframe_reset");
        ps2_d = 1'b1;
        rst_n = 1'b1;
        wait_cyc(20);
        push_key(8'h1C, 1'b1, 1'b0); send(8'h1C);

        // reset in the middle of PAUSE
        send(8'hE1); send(8'h14);
        rst_n = 1'b0;
        wait_cyc(3);
        check_reset_outputs("pause_reset");
        rst_n = 1'b1;
        wait_cyc(20);
        push_key(8'h29, 1'b1, 1'b0); send(8'h29);

        wait_cyc(100);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
